sig_hint_pack_stream: RTL
=========================

SIG_HINT_PACK_STREAM -- requirements
Module: sig_hint_pack_stream

Interface
REQ-001 SHALL have parameter K, default 6: number of hint polynomials.
REQ-002 SHALL have parameter N, default 256: coefficients per polynomial; N SHALL be at most 256 so each index fits one byte.
REQ-003 SHALL have parameter OMEGA, default 55: maximum total hint weight; index buffer depth.
REQ-004 SHALL have port clk, input, 1: the only clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: begin a new packing job; sampled only in IDLE.
REQ-007 SHALL have port in_valid, input, 1: in_bits holds one hint polynomial.
REQ-008 SHALL have port in_ready, output, 1: block accepts a polynomial.
REQ-009 SHALL have port in_bits, input, N: hint bits; bit j is coefficient j of the current polynomial.
REQ-010 SHALL have port out_valid, output, 1: out_byte is valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts out_byte.
REQ-012 SHALL have port out_byte, output, 8: encoded hint byte.
REQ-013 SHALL have port out_last, output, 1: marks byte OMEGA+K-1.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when the job completes.
REQ-016 SHALL have port overflow, output, 1: total weight exceeded OMEGA; held until the next start.

Function
REQ-017 SHALL implement states IDLE, LOAD, SCAN, EMIT.
REQ-018 IDLE: start=1 SHALL clear the polynomial counter p, fill pointer kpos and overflow, then go to LOAD; start in any other state SHALL be ignored.
REQ-019 LOAD: in_ready=1 only here; on in_valid&in_ready SHALL register in_bits, clear coefficient counter j, go to SCAN.
REQ-020 SCAN: SHALL examine one coefficient per cycle, j = 0..N-1 ascending, so each polynomial occupies exactly N SCAN cycles.
REQ-021 SCAN: if bit j=1 and kpos<OMEGA, SHALL write j[7:0] to idx[kpos] and increment kpos.
REQ-022 SCAN: if bit j=1 and kpos=OMEGA, SHALL drop the index, leave kpos unchanged and set overflow.
REQ-023 SCAN end (j=N-1): SHALL store cnt[p] = kpos value after that cycle's update; if p=K-1 go to EMIT, else increment p and go to LOAD.
REQ-024 EMIT: SHALL present OMEGA+K bytes in order, index e = 0..OMEGA+K-1.
REQ-025 EMIT, e<OMEGA: out_byte SHALL be idx[e] if e<kpos, else 8'h00; the index buffer SHALL NOT need explicit clearing.
REQ-026 EMIT, e>=OMEGA: out_byte SHALL be cnt[e-OMEGA].
REQ-027 out_valid SHALL be 1 throughout EMIT; e SHALL advance only on out_valid&out_ready; out_byte and out_last SHALL hold stable while out_ready=0.
REQ-028 out_last SHALL be 1 exactly when e=OMEGA+K-1.
REQ-029 On the final handshake, SHALL return to IDLE and pulse done for the next cycle; overflow SHALL remain valid alongside done.
REQ-030 Total job latency with no stalls SHALL be K*(N+1) + OMEGA+K cycles from the first in_valid acceptance to done.

Reset
REQ-031 rst=1 SHALL force state IDLE and in_ready=0, out_valid=0, out_byte=0, out_last=0, busy=0, done=0, overflow=0, with p=j=kpos=e=0.
REQ-032 rst SHALL take priority over start and all handshakes, including mid-SCAN or mid-EMIT; partial jobs SHALL be discarded and no done pulse issued.

Verification
REQ-033 All-zero hint, K=6, OMEGA=55: 61 bytes all 8'h00, out_last on byte 60, overflow=0, done one cycle after the final handshake.
REQ-034 poly0 bits {3,200}, poly2 bit {255}, others zero: bytes 03,C8,FF, then 52 zeros, then counts 02,02,03,03,03,03.
REQ-035 poly0 bits 0..59 all set: idx bytes 00..36 (55 entries), counts 37 x6 (hex), overflow=1.
REQ-036 Random hints, out_ready toggled randomly and in_valid delayed: byte stream identical to the stall-free run; out_byte stable during every stall.
REQ-037 rst asserted in SCAN of poly 3, then a new job: outputs at reset values next cycle; the new job's output is independent of the aborted data.
REQ-038 K=4, OMEGA=80 instance, 10 random hint bits per poly: 84 bytes, counts 0A,14,1E,28, overflow=0.

Source files
------------

// File: rtl/sig_hint_pack_stream.sv
// Hint packer: scans K polynomials of N hint bits and streams OMEGA index bytes
// followed by K cumulative-count bytes over a valid/ready byte port.
module sig_hint_pack_stream #(
  parameter int K     = 6,
  parameter int N     = 256,
  parameter int OMEGA = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         overflow
);
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (K > 1) ? $clog2(K) : 1;
  localparam int IW = (OMEGA > 1) ? $clog2(OMEGA) : 1;
  localparam int KW = $clog2(OMEGA + 1);
  localparam int EW = $clog2(OMEGA + K);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SCAN = 2'd2, EMIT = 2'd3} state_t;

  state_t        state_r;
  logic [N-1:0]  bits_r;
  logic [JW-1:0] j_r;
  logic [PW-1:0] p_r;
  logic [KW-1:0] kpos_r;
  logic [EW-1:0] e_r;
  logic [7:0]    idx_r [OMEGA];
  logic [7:0]    cnt_r [K];

  logic          bit_s;
  logic          wr_s;
  logic          drop_s;
  logic          scan_end_s;
  logic [KW-1:0] kpos_nxt_s;
  logic [EW-1:0] nxt_e_s;
  logic [EW-1:0] ofs_s;
  logic [7:0]    nxt_byte_s;
  logic [7:0]    first_byte_s;

  // Per-coefficient decision: record the index, or drop it once the buffer is full
  always_comb begin
    bit_s      = 1'b0;
    wr_s       = 1'b0;
    drop_s     = 1'b0;
    scan_end_s = 1'b0;
    kpos_nxt_s = kpos_r;
    if (state_r == SCAN) begin
      bit_s      = bits_r[j_r];
      scan_end_s = (j_r == JW'(N - 1));
      if (bit_s && (kpos_r < KW'(OMEGA))) begin
        wr_s       = 1'b1;
        kpos_nxt_s = kpos_r + KW'(1'b1);
      end else begin
        drop_s = bit_s;
      end
    end else begin
      bit_s = 1'b0;
    end
  end

  // Byte for the next stream position; the entry byte bypasses a same-cycle idx write
  always_comb begin
    nxt_byte_s   = 8'h00;
    first_byte_s = 8'h00;
    nxt_e_s      = e_r + EW'(1'b1);
    ofs_s        = nxt_e_s - EW'(OMEGA);
    if (nxt_e_s < EW'(OMEGA)) begin
      if (32'(nxt_e_s) < 32'(kpos_r)) begin
        nxt_byte_s = idx_r[nxt_e_s[IW-1:0]];
      end else begin
        nxt_byte_s = 8'h00;
      end
    end else begin
      nxt_byte_s = cnt_r[ofs_s[PW-1:0]];
    end
    if (kpos_nxt_s == KW'(1'b0)) begin
      first_byte_s = 8'h00;
    end else if (wr_s && (kpos_r == KW'(1'b0))) begin
      first_byte_s = 8'(j_r);
    end else begin
      first_byte_s = idx_r[0];
    end
  end

  // Index and count storage; entries are only read behind kpos/p, so never cleared
  always_ff @(posedge clk) begin
    if (wr_s) begin
      idx_r[kpos_r[IW-1:0]] <= 8'(j_r);
    end
    if (scan_end_s) begin
      cnt_r[p_r] <= 8'(kpos_nxt_s);
    end
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bits_r    <= '0;
      j_r       <= '0;
      p_r       <= '0;
      kpos_r    <= '0;
      e_r       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            p_r      <= '0;
            kpos_r   <= '0;
            overflow <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state_r  <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            bits_r   <= in_bits;
            j_r      <= '0;
            in_ready <= 1'b0;
            state_r  <= SCAN;
          end
        end
        SCAN: begin
          kpos_r <= kpos_nxt_s;
          if (drop_s) begin
            overflow <= 1'b1;
          end
          if (scan_end_s) begin
            if (p_r == PW'(K - 1)) begin
              e_r       <= '0;
              out_valid <= 1'b1;
              out_byte  <= first_byte_s;
              out_last  <= 1'b0;
              state_r   <= EMIT;
            end else begin
              p_r      <= p_r + PW'(1'b1);
              in_ready <= 1'b1;
              state_r  <= LOAD;
            end
          end else begin
            j_r <= j_r + JW'(1'b1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_byte  <= 8'h00;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_r   <= IDLE;
            end else begin
              e_r      <= nxt_e_s;
              out_byte <= nxt_byte_s;
              out_last <= (nxt_e_s == EW'(OMEGA + K - 1));
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
